vproj_mem_ctrl: RTL and testbench
=================================

// Module: vproj_mem_ctrl
// PURPOSE
//  Owns the V-projection weight SRAM wrapper (sram128x128_vproj) and shares it between two users.
//  - Weight loader: row writes via a valid/ready port.
//  - Compute datapath: burst row reads via a start/done command, delivered on a back-pressured stream.
//  Hides the wrapper's fixed read latency with a credit-controlled output FIFO.
// PARAMETERS
//  DEPTH      128  SRAM rows; row addresses wrap modulo DEPTH
//  ADDR_W     7    row address width, = $clog2(DEPTH)
//  DATA_W     128  row width in bits
//  READ_LAT   2    must match the wrapper's READ_LAT; total SRAM latency L = READ_LAT+1
//  FIFO_DEPTH 4    output FIFO entries; >= L+1 sustains one row/cycle; legal minimum is 1
// PORTS
//  clk            in   1         clock
//  rst_n          in   1         async active-low reset
//  wr_valid       in   1         loader write request
//  wr_ready       out  1         write accepted when wr_valid & wr_ready
//  wr_addr        in   ADDR_W    write row
//  wr_data        in   DATA_W    write data
//  start          in   1         one-cycle burst-read command
//  base_addr      in   ADDR_W    first row of burst, sampled on accepted start
//  row_count      in   ADDR_W+1  rows in burst, sampled on accepted start
//  busy           out  1         burst in progress
//  done           out  1         one-cycle pulse after the last beat is accepted
//  out_valid      out  1         read stream valid
//  out_ready      in   1         read stream ready
//  out_data       out  DATA_W    row data
//  out_last       out  1         final beat of burst
//  mem_init_en    out  1         to wrapper init_en
//  mem_init_we_n  out  1         to wrapper init_we_n
//  mem_init_addr  out  ADDR_W    to wrapper init_addr
//  mem_init_din   out  DATA_W    to wrapper init_din
//  mem_rd_addr    out  ADDR_W    to wrapper rd_addr
//  mem_rd_dout    in   DATA_W    from wrapper rd_dout
// BEHAVIOUR
//  Reset values
//  - State IDLE; busy=0, done=0, out_valid=0, out_last=0.
//  - mem_init_en=0, mem_init_we_n=1, all addresses 0.
//  - wr_ready=1 (IDLE); FIFO, in-flight and credit state cleared.
//  Write path
//  - wr_ready=1 only in IDLE.
//  - On accept, same cycle (combinational): mem_init_en=1, mem_init_we_n=0, mem_init_addr=wr_addr, mem_init_din=wr_data.
//  FSM
//  - IDLE->ISSUE on start with row_count!=0; start with row_count==0 is ignored (no busy, no done).
//  - row_count>DEPTH is clamped to DEPTH.
//  - start while busy is ignored.
//  - Simultaneous start and write in IDLE: write accepted this cycle, first read issues next cycle (read-after-write ordering).
//  Issue
//  - In ISSUE, a read issues when fifo_count + inflight < FIFO_DEPTH.
//  - Issue presents rd_ptr on mem_rd_addr; rd_ptr increments modulo DEPTH (127->0 wrap).
//  - After the row_count-th issue -> DRAIN.
//  Return
//  - L-bit valid shift register with a last tag; a read issued in cycle t pushes mem_rd_dout into the FIFO in cycle t+L.
//  - The credit rule guarantees no FIFO overflow; no data is dropped.
//  Drain and done
//  - DRAIN->IDLE when the out_last beat is accepted.
//  - done pulses the cycle after the out_last accept; busy falls that same cycle.
//  Output stream
//  - out_valid holds until accepted; out_data and out_last stay stable while out_valid & !out_ready.
//  - Full-throughput target: one beat/cycle when out_ready=1 and FIFO_DEPTH>=L+1.
//  Reset mid-burst
//  - Everything aborts; no done.
//  - In-flight data is discarded (the wrapper pipeline shares rst_n).
//  - mem_rd_dout observed while the init port is active is ignored (no in-flight tag).
// CONFIGURATION
//  `VPROJ_CTRL_PERF_EN` defined
//  - Adds outputs perf_stall_cycles[31:0] (cycles with out_valid & !out_ready) and perf_burst_cycles[31:0] (cycles with busy=1).
//  - Both counters clear on accepted start and saturate at all-ones.
//  `VPROJ_CTRL_PERF_EN` undefined
//  - Ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - vproj_pkg: DEPTH, ADDR_W, DATA_W constants; typedef enum {IDLE, ISSUE, DRAIN} vproj_ctrl_state_e.
//  - Sub-module vproj_rd_fifo: sync FIFO, DATA_W+1 wide (data+last), FIFO_DEPTH entries, count output.
// TESTING (bench instantiates this block + sram128x128_vproj, READ_LAT=2)
//  1. Load rows 0..127 with data=row*0x0101.., then start base=0 count=128, out_ready=1
//     -> 128 beats in order, one/cycle after L-cycle fill, out_last on beat 127, done 1 cycle later.
//  2. base=126 count=4 -> rows 126,127,0,1; out_last on row 1.
//  3. Random out_ready (50%) over count=64 -> no loss or duplication, data stable under stall, inflight+fifo never >4.
//  4. start and wr_valid(addr=5) same cycle, base=5 count=1 -> write accepted; returned beat is the new row 5 data.
//  5. wr_valid during busy -> wr_ready=0 until done. start during busy -> ignored. start with count=0 -> no busy, no done.
//  6. rst_n low mid-burst (after 10 beats) -> outputs at reset values; new start count=2 returns exactly 2 correct beats.

Source files
------------

// File: rtl/vproj_pkg.sv
// Shared constants and types for the V-projection weight SRAM controller.
//   DEPTH/ADDR_W/DATA_W : SRAM geometry (128 rows x 128 bits)
//   vproj_ctrl_state_e  : burst-read controller state
//   vproj_beat_t        : one output-stream beat (row data + end-of-burst tag)
package vproj_pkg;

  localparam int unsigned DEPTH  = 128;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } vproj_ctrl_state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } vproj_beat_t;

endpackage

// File: rtl/vproj_rd_fifo.sv
// Synchronous FIFO buffering returned SRAM rows ahead of the output stream.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_push     : write i_din (caller guarantees space via credit control)
//   i_din      : entry to write
//   i_pop      : consume the head entry (ignored when empty)
//   o_dout     : head entry, stable until popped
//   o_empty    : no entries held
//   o_count    : number of entries held
module vproj_rd_fifo #(
  parameter int unsigned WIDTH   = 129,
  parameter int unsigned DEPTH_F = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_push,
  input  logic [WIDTH-1:0]                 i_din,
  input  logic                             i_pop,
  output logic [WIDTH-1:0]                 o_dout,
  output logic                             o_empty,
  output logic [$clog2(DEPTH_F+1)-1:0]     o_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH_F + 1);
  localparam int unsigned PTR_W = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH_F];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH_F - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop   = i_pop && (r_count != '0);
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH_F); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vproj_mem_ctrl.sv
// Shares the V-projection weight SRAM wrapper between a row loader (writes)
// and the compute datapath (burst reads on a back-pressured stream).
// Optional feature macro: VPROJ_CTRL_PERF_EN adds perf_stall_cycles and
// perf_burst_cycles counters.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data  : loader write port (accepted only in IDLE)
//   start/base_addr/row_count          : burst-read command
//   busy, done                         : burst in progress / completion pulse
//   out_valid/out_ready/out_data/out_last : read stream
//   mem_init_*                         : wrapper write port (combinational from accepted write)
//   mem_rd_addr, mem_rd_dout           : wrapper read port
module vproj_mem_ctrl
  import vproj_pkg::*;
#(
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   row_count,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              mem_init_en,
  output logic              mem_init_we_n,
  output logic [ADDR_W-1:0] mem_init_addr,
  output logic [DATA_W-1:0] mem_init_din,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_dout
`ifdef VPROJ_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_burst_cycles
`endif
);

  localparam int unsigned LAT    = READ_LAT + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W  = $clog2(FIFO_DEPTH + LAT + 2);
  localparam int unsigned RCNT_W = ADDR_W + 1;

  vproj_ctrl_state_e r_state, w_state_next;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [RCNT_W-1:0] r_remain;
  logic [LAT-1:0]    r_vld_sr;
  logic [LAT-1:0]    r_last_sr;
  logic              r_done;

  logic              w_wr_acc;
  logic              w_start_acc;
  logic              w_issue;
  logic              w_last_pop;
  logic              w_pop;
  logic              w_credit_ok;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [SUM_W-1:0]  w_inflight;
  logic [RCNT_W-1:0] w_count_clamped;
  logic              w_final_issue;
  vproj_beat_t       w_fifo_din;
  vproj_beat_t       w_fifo_dout;

  assign w_count_clamped = (row_count > RCNT_W'(DEPTH)) ? RCNT_W'(DEPTH) : row_count;
  assign w_final_issue   = (r_remain == RCNT_W'(1));

  // Reads still in the wrapper pipeline
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < int'(LAT); i++) w_inflight = w_inflight + SUM_W'(r_vld_sr[i]);
  end

  // Every issued read owns a FIFO slot; a slot freed by this cycle's pop counts as free.
  assign w_credit_ok = (SUM_W'(w_fifo_count) + w_inflight) < (SUM_W'(FIFO_DEPTH) + SUM_W'(w_pop));

  // Next-state and per-cycle strobes
  always_comb begin
    w_state_next = r_state;
    w_wr_acc     = 1'b0;
    w_start_acc  = 1'b0;
    w_issue      = 1'b0;
    w_last_pop   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_wr_acc = wr_valid;
        if (start && (row_count != '0)) begin
          w_start_acc  = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (w_final_issue) w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && w_fifo_dout.last) begin
          w_last_pop   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Burst address/length tracking; ADDR_W-bit increment wraps modulo DEPTH (power of two)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_remain <= '0;
    end else if (w_start_acc) begin
      r_rd_ptr <= base_addr;
      r_remain <= w_count_clamped;
    end else if (w_issue) begin
      r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_remain <= r_remain - RCNT_W'(1);
    end
  end

  // Return-path tags: bit LAT-1 marks the cycle the wrapper presents that read's data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr  <= '0;
      r_last_sr <= '0;
      r_done    <= 1'b0;
    end else begin
      r_vld_sr  <= {r_vld_sr[LAT-2:0], w_issue};
      r_last_sr <= {r_last_sr[LAT-2:0], w_issue && w_final_issue};
      r_done    <= w_last_pop;
    end
  end

  assign w_fifo_din.last = r_last_sr[LAT-1];
  assign w_fifo_din.data = mem_rd_dout;

  vproj_rd_fifo #(
    .WIDTH   ($bits(vproj_beat_t)),
    .DEPTH_F (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_vld_sr[LAT-1]),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_pop     = !w_fifo_empty && out_ready;
  assign out_valid = !w_fifo_empty;
  assign out_data  = w_fifo_dout.data;
  assign out_last  = w_fifo_dout.last;

  assign wr_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign done     = r_done;

  assign mem_init_en   = w_wr_acc;
  assign mem_init_we_n = !w_wr_acc;
  assign mem_init_addr = w_wr_acc ? wr_addr : '0;
  assign mem_init_din  = w_wr_acc ? wr_data : '0;
  assign mem_rd_addr   = r_rd_ptr;

`ifdef VPROJ_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_burst;

  // Saturating stall / burst-length counters, cleared by each accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_burst <= '0;
    end else if (w_start_acc) begin
      r_perf_stall <= '0;
      r_perf_burst <= '0;
    end else begin
      if (out_valid && !out_ready && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if (busy && (r_perf_burst != '1))                    r_perf_burst <= r_perf_burst + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_burst_cycles = r_perf_burst;
`endif

endmodule

// File: tb/tb_vproj_mem_ctrl.sv
// Directed bench for vproj_mem_ctrl with a behavioural model of the
// sram128x128_vproj wrapper (READ_LAT=2, total read latency 3).
module tb_vproj_mem_ctrl;
  import vproj_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   row_count = '0;
  logic              busy, done, out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;
  logic              mem_init_en, mem_init_we_n;
  logic [ADDR_W-1:0] mem_init_addr, mem_rd_addr;
  logic [DATA_W-1:0] mem_init_din, mem_rd_dout;
`ifdef VPROJ_CTRL_PERF_EN
  logic [31:0]       perf_stall_cycles, perf_burst_cycles;
`endif

  always #5 clk = ~clk;

  vproj_mem_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .start         (start),
    .base_addr     (base_addr),
    .row_count     (row_count),
    .busy          (busy),
    .done          (done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .mem_init_en   (mem_init_en),
    .mem_init_we_n (mem_init_we_n),
    .mem_init_addr (mem_init_addr),
    .mem_init_din  (mem_init_din),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_dout   (mem_rd_dout)
`ifdef VPROJ_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_burst_cycles (perf_burst_cycles)
`endif
  );

  // Wrapper model: registered address plus two output stages
  logic [DATA_W-1:0] sram [DEPTH];
  logic [DATA_W-1:0] p0, p1, p2;
  always @(posedge clk) if (mem_init_en && !mem_init_we_n) sram[mem_init_addr] <= mem_init_din;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0 <= '0; p1 <= '0; p2 <= '0;
    end else begin
      p0 <= sram[mem_rd_addr]; p1 <= p0; p2 <= p1;
    end
  end
  assign mem_rd_dout = p2;

  // Stream ready: fixed level or random per cycle
  logic rand_rdy = 1'b0, rdy_fixed = 1'b0, r_rnd = 1'b0;
  always @(posedge clk) r_rnd <= 1'($urandom_range(0, 1));
  assign out_ready = rand_rdy ? r_rnd : rdy_fixed;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [DATA_W-1:0] exp_mem [DEPTH];

  task automatic chk(input string tag, input logic [DATA_W:0] obs, input logic [DATA_W:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: accepted beats, done pulses, stall stability
  logic [DATA_W:0] beats[$];
  int              acc_cyc[$];
  int              done_cnt = 0;
  int              done_cyc = 0;
  logic            done_busy = 1'b0;
  logic            prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic            prev_last = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", out_valid, 1);
        chk("stall_data_hold", out_data, prev_data);
        chk("stall_last_hold", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        beats.push_back({out_last, out_data});
        acc_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  function automatic logic [DATA_W-1:0] rowdat(input int r);
    logic [7:0] b;
    b = 8'(r);
    return {16{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int a, input logic [DATA_W-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(a);
    wr_data  = d;
    for (int i = 0; i < 200 && !wr_ready; i++) tick();
    chk("write_ready", wr_ready, 1);
    tick();
    exp_mem[a] = d;
    wr_valid = 1'b0;
  endtask

  task automatic start_burst(input int base, input int cnt);
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    row_count = (ADDR_W+1)'(cnt);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic check_burst(input string tag, input int b0, input int base, input int n);
    int got;
    got = beats.size() - b0;
    chk({tag, "_beats"}, got, n);
    for (int i = 0; i < n && i < got; i++) begin
      chk({tag, "_data"}, beats[b0+i][DATA_W-1:0], exp_mem[(base + i) % DEPTH]);
      chk({tag, "_last"}, beats[b0+i][DATA_W], (i == n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int b0, d0, n;
    logic [DATA_W-1:0] d5, d30;

    // Reset values
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_init_en", mem_init_en, 0);
    chk("rst_init_we_n", mem_init_we_n, 1);
    chk("rst_rd_addr", mem_rd_addr, 0);
    rst_n = 1'b1;
    tick();

    // 1: full-array load and 128-row burst at full throughput
    for (int r = 0; r < int'(DEPTH); r++) write_row(r, rowdat(r));
    rdy_fixed = 1'b1;
    b0 = beats.size();
    start_burst(0, 128);
    wait_done("t1_done", 400);
    tick(); tick();
    check_burst("t1", b0, 0, 128);
    if (beats.size() >= b0 + 128) begin
      chk("t1_throughput", acc_cyc[b0+127] - acc_cyc[b0], 127);
      chk("t1_done_lat", done_cyc - acc_cyc[b0+127], 1);
    end
    chk("t1_busy_at_done", done_busy, 0);
    chk("t1_idle_after", busy, 0);

    // 2: address wrap 126,127,0,1
    b0 = beats.size();
    start_burst(126, 4);
    wait_done("t2_done", 100);
    tick(); tick();
    check_burst("t2", b0, 126, 4);

    // 3: random back-pressure
    rand_rdy = 1'b1;
    b0 = beats.size();
    start_burst(10, 64);
    wait_done("t3_done", 2000);
    rand_rdy = 1'b0;
    tick(); tick();
    check_burst("t3", b0, 10, 64);

    // 4: simultaneous write and start, read returns new data
    d5 = ~rowdat(5);
    b0 = beats.size();
    wr_valid = 1'b1; wr_addr = 7'd5; wr_data = d5;
    start = 1'b1; base_addr = 7'd5; row_count = 8'd1;
    #1;
    chk("t4_wr_ready", wr_ready, 1);
    chk("t4_init_en", mem_init_en, 1);
    chk("t4_init_we_n", mem_init_we_n, 0);
    chk("t4_init_addr", mem_init_addr, 5);
    tick();
    wr_valid = 1'b0; start = 1'b0;
    exp_mem[5] = d5;
    wait_done("t4_done", 100);
    tick(); tick();
    check_burst("t4", b0, 5, 1);

    // 5: write and start while busy, then zero-length start
    rdy_fixed = 1'b0;
    b0 = beats.size();
    d0 = done_cnt;
    start_burst(20, 16);
    for (int i = 0; i < 8; i++) tick();
    chk("t5_busy", busy, 1);
    d30 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    wr_valid = 1'b1; wr_addr = 7'd30; wr_data = d30;
    #1;
    chk("t5_wr_blocked", wr_ready, 0);
    chk("t5_init_idle", mem_init_en, 0);
    start_burst(0, 5);
    rdy_fixed = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (!done) chk("t5_wr_blocked_run", wr_ready, 0);
    end
    chk("t5_done_seen", done, 1);
    chk("t5_wr_ready_at_done", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_burst("t5", b0, 20, 16);
    chk("t5_one_done", done_cnt - d0, 1);
    exp_mem[30] = d30;
    b0 = beats.size();
    d0 = done_cnt;
    start_burst(7, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_zero_busy", busy, 0);
    chk("t5_zero_done", done_cnt - d0, 0);
    chk("t5_zero_beats", beats.size() - b0, 0);

    // 6: reset mid-burst, then a clean 2-row burst
    b0 = beats.size();
    d0 = done_cnt;
    start_burst(25, 64);
    for (int i = 0; i < 200 && (beats.size() - b0) < 10; i++) tick();
    chk("t6_reached_10", (beats.size() - b0) >= 10 ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_out_last", out_last, 0);
    chk("t6_rst_wr_ready", wr_ready, 1);
    chk("t6_rst_rd_addr", mem_rd_addr, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t6_no_done", done_cnt - d0, 0);
    b0 = beats.size();
    start_burst(30, 2);
    wait_done("t6_done", 100);
    for (int i = 0; i < 10; i++) tick();
    n = beats.size() - b0;
    check_burst("t6", b0, 30, 2);
    chk("t6_exact_beats", n, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
